// File: rtl/calc_pkg.sv
// Shared calculator package: FSM states, display blank code, opcodes, defaults.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam int unsigned DIGITS_DEFAULT = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    // Pre-shift correction so the digit carries correctly after the left shift
    always_comb begin
        dout_c = din;
        if (din >= 4'd5) begin
            dout_c = din + 4'd3;
        end
    end

endmodule

// File: rtl/int_result_bcd.sv
// int_result_bcd: sequential binary-to-BCD converter for calculator results.
// Optional build macro INT_RESULT_BCD_LZB_EN enables leading-zero blanking.
module int_result_bcd
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIGITS      = DIGITS_DEFAULT,
    parameter int unsigned SIGNED_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_sign,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_sign,
    output logic [2:0]            out_ndigits
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    // Digit count must cover the largest magnitude; ndigits is a 3-bit field
    generate
        if (pow10(DIGITS) <= MAX_BIN || DIGITS > 7) begin : g_bad_digits
            $error("int_result_bcd: DIGITS too small for WIDTH or too large for out_ndigits");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_sign_q, out_sign_d;
    logic [2:0]         out_ndigits_q, out_ndigits_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [WIDTH-1:0]   mag_shift;
    logic [BCD_W-1:0]   bcd_final;
    logic [2:0]         nd;
    logic               in_neg_raw;
    logic [WIDTH-1:0]   in_mag;
    logic               in_neg;

    // Per-digit add-3 correctors on the current accumulator
    generate
        for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din    (bcd_q[4*g +: 4]),
                .dout_c (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // Input magnitude and sign; negative zero is reported as positive
    always_comb begin
        in_neg_raw = (SIGNED_MODE != 0) ? in_value[WIDTH-1] : in_sign;
        in_mag     = in_value;
        if (SIGNED_MODE != 0 && in_value[WIDTH-1]) begin
            in_mag = (~in_value) + WIDTH'(1);
        end
        in_neg = in_neg_raw && (in_value != '0);
    end

    // One double-dabble step: corrected digits and magnitude shift left together
    always_comb begin
        bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_shift = {mag_q[WIDTH-2:0], 1'b0};
    end

    // Significant-digit count and optional leading-zero blanking of the final value
    always_comb begin
        nd = 3'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                nd = 3'(i + 1);
            end
        end
        bcd_final = bcd_shift;
`ifdef INT_RESULT_BCD_LZB_EN
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (3'(i) >= nd) begin
                bcd_final[4*i +: 4] = BCD_BLANK;
            end
        end
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        bcd_d         = bcd_q;
        sign_d        = sign_q;
        cnt_d         = cnt_q;
        out_bcd_d     = out_bcd_q;
        out_sign_d    = out_sign_q;
        out_ndigits_d = out_ndigits_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mag_d      = in_mag;
                    sign_d     = in_neg;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_bcd_d     = bcd_final;
                    out_sign_d    = sign_q;
                    out_ndigits_d = nd;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            bcd_q         <= '0;
            sign_q        <= 1'b0;
            cnt_q         <= '0;
            out_bcd_q     <= '0;
            out_sign_q    <= 1'b0;
            out_ndigits_q <= 3'd1;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            bcd_q         <= bcd_d;
            sign_q        <= sign_d;
            cnt_q         <= cnt_d;
            out_bcd_q     <= out_bcd_d;
            out_sign_q    <= out_sign_d;
            out_ndigits_q <= out_ndigits_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_bcd     = out_bcd_q;
    assign out_sign    = out_sign_q;
    assign out_ndigits = out_ndigits_q;

endmodule

// File: doc/int_result_bcd.md
Name: int_result_bcd

Overview:
- Downstream stage of the 16-bit integer calculator. Consumes its result word and sign flag.
- Converts the binary magnitude to packed BCD with a sequential double-dabble (shift-and-add-3), one bit per clock.
- Presents decimal digits, sign and significant-digit count to the display driver over a valid/ready handshake.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD digit count. Elaboration error unless 10^DIGITS > 2^WIDTH-1.
- SIGNED_MODE, 0:
  - 0: in_value is an unsigned magnitude and in_sign passes through.
  - 1: in_value is two's complement, in_sign is ignored, and the sign is derived from the MSB.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  calculator result available
- in_ready  output  1  block idle, can accept a result
- in_value  input  WIDTH  calculator result word
- in_sign  input  1  calculator sign flag (SIGNED_MODE=0 only)
- out_valid  output  1  BCD result available
- out_ready  input  1  display driver accepts the result
- out_bcd  output  4*DIGITS  packed BCD, most significant digit in the top nibble
- out_sign  output  1  1 = negative
- out_ndigits  output  3  significant digits, 1..DIGITS (zero counts as 1)

Behaviour:
- Reset values (clocked, reset high): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_sign=0, out_ndigits=1, shift counter=0, internal registers=0.
- Reset mid-conversion or while in DONE: the conversion is abandoned, there is no output, and the block returns to IDLE the cycle after reset deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch magnitude and sign, clear the BCD accumulator, counter=0, go to SHIFT.
  - SIGNED_MODE=1 with MSB set: magnitude = two's-complement negation (0x8000 -> 32768), sign=1.
  - SHIFT and DONE hold in_ready=0.
- SHIFT:
  - Each cycle, every BCD digit >=5 gets +3, then {bcd,mag} shifts left by 1 and the counter increments.
  - After WIDTH cycles go to DONE and register out_bcd, out_sign and out_ndigits.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge (16 by default).
- DONE:
  - out_valid=1; outputs stable and held while out_ready=0 (indefinite backpressure allowed).
  - On out_valid&&out_ready: out_valid=0 next cycle, go to IDLE, in_ready=1 next cycle.
  - No input is accepted in the same cycle as output release; throughput is one result per WIDTH+2 cycles minimum.
- out_ndigits = 1 + index of the highest nonzero digit; an all-zero result gives 1.
- Negative zero (in_sign=1, value 0) outputs out_sign=0.
- Outputs are undefined-free: out_bcd holds its last value when out_valid=0.
- Every digit is 0..9 (except blanking below).
- Saturation cannot occur, by the DIGITS rule.

Optional Feature:
- INT_RESULT_BCD_LZB_EN (leading-zero blanking):
  - Defined: digits above out_ndigits are driven 4'hF (blank code) in out_bcd. The least significant digit is never blanked.
  - Undefined: leading zeros are output as 4'h0.
- out_ndigits is identical in both builds.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_BLANK=4'hF;
  - calculator opcode constants (ADD=3'b000 .. MOD=3'b111) shared with the calculator stage;
  - DIGITS default constant.
- One sub-module: bcd_digit_adj, a 4-bit combinational add-3-if-≥5 corrector, instantiated DIGITS times by a generate loop.

Test Plan:
- Reset, then in_value=0, in_sign=0 -> after 16 cycles out_bcd=0x00000, out_ndigits=1, out_sign=0; LZB build: 0xFFFF0.
- in_value=65535 -> out_bcd=0x65535, out_ndigits=5; out_valid exactly 16 cycles after acceptance.
- in_value=42, in_sign=1, out_ready low for 7 cycles after out_valid -> out_bcd=0x00042 (LZB 0xFFF42), out_sign=1, ndigits=2, all held stable; in_ready=0 throughout, 1 the cycle after release.
- SIGNED_MODE=1, in_value=0x8000 -> out_bcd=0x32768, out_sign=1; in_value=0xFFFF -> 0x00001, out_sign=1.
- Assert reset at SHIFT cycle 8 of converting 1234 -> out_valid stays 0 and in_ready=1 after reset. A following input 9 -> 0x00009, ndigits=1.
- Back-to-back: in_valid held high with 100 then 200, out_ready=1 -> two results 0x00100 then 0x00200, in order, each ndigits=3, separated by ≥18 cycles.
